// File: rtl/result_pkg.sv
// Shared definitions for the path result streamer: default widths, the
// terminator/separator word values and the streamer FSM state encoding.
package result_pkg;

  localparam int ADDR_W_DEF    = 14;
  localparam int DATA_W_DEF    = 16;
  localparam int MAX_WORDS_DEF = 16383;

  localparam logic [15:0] TERM_WORD = 16'h0000;
  localparam logic [15:0] SEP_WORD  = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RD    = 3'd2,
    WT    = 3'd3,
    HOLD  = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/result_out_reg.sv
// Output holding register: captures one result word (or a synthesized
// negative-cycle beat), decodes its flags and holds it until accepted.
module result_out_reg
  import result_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_word,
  input  logic              load_neg,
  input  logic              at_max,
  input  logic [DATA_W-1:0] word,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              sep,
  output logic              neg,
  output logic              last
);

  logic is_term;
  logic is_sep;

  assign is_term = (word == DATA_W'(TERM_WORD));
  assign is_sep  = (word == DATA_W'(SEP_WORD));

  // Flags are only updated on a load, so they stay put for the whole stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      sep   <= 1'b0;
      neg   <= 1'b0;
      last  <= 1'b0;
    end else if (load_neg) begin
      valid <= 1'b1;
      data  <= '0;
      sep   <= 1'b0;
      neg   <= 1'b1;
      last  <= 1'b1;
    end else if (load_word) begin
      valid <= 1'b1;
      data  <= word;
      sep   <= is_sep;
      neg   <= 1'b0;
      last  <= is_term | at_max;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/path_result_streamer.sv
// Streams solver path results out of the result memory as valid/ready beats,
// one word per read, stopping on the terminator word or the scan limit.
module path_result_streamer
  import result_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              n_exist,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sep,
  output logic              out_neg,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr;
  logic              neg_q;
  logic              at_max;
  logic              accept;
  logic              load_word;
  logic              load_neg;

  assign at_max   = (addr == LAST_ADDR);
  assign accept   = out_valid && out_ready;
  assign mem_addr = addr;
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      neg_q   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        addr    <= '0;
        neg_q   <= n_exist;
        overrun <= 1'b0;
      end
      if (state == HOLD && accept && !out_last) begin
        addr <= addr + ADDR_W'(1);
      end
      // Scan limit reached without seeing the terminator.
      if (load_word && at_max && (mem_rdata != DATA_W'(TERM_WORD))) begin
        overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    mem_rd_en = 1'b0;
    load_word = 1'b0;
    load_neg  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = CHECK;
      end
      CHECK: begin
        if (neg_q) begin
          load_neg = 1'b1;
          state_nx = HOLD;
        end else begin
          state_nx = RD;
        end
      end
      RD: begin
        mem_rd_en = 1'b1;
        state_nx  = WT;
      end
      WT: begin
        load_word = 1'b1;
        state_nx  = HOLD;
      end
      HOLD: begin
        if (accept) state_nx = out_last ? DONE : RD;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  result_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clock     (clock),
    .reset     (reset),
    .load_word (load_word),
    .load_neg  (load_neg),
    .at_max    (at_max),
    .word      (mem_rdata),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (out_data),
    .sep       (out_sep),
    .neg       (out_neg),
    .last      (out_last)
  );

endmodule

// File: tb/tb_path_result_streamer.sv
// Directed bench for path_result_streamer with a one-cycle-latency memory model.
module tb_path_result_streamer;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 16;
  localparam int MAX_WORDS = 16383;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic              n_exist;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sep;
  logic              out_neg;
  logic              out_last;
  logic              busy;
  logic              overrun;

  typedef struct packed {
    logic [15:0] data;
    logic        sep;
    logic        neg;
    logic        last;
  } beat_t;

  logic [15:0] mem [0:16383];
  beat_t       beats[$];
  logic [13:0] rd_addrs[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clock = ~clock;

  path_result_streamer #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .n_exist   (n_exist),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sep   (out_sep),
    .out_neg   (out_neg),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  always @(posedge clock) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  always @(negedge clock) begin
    if (out_valid && out_ready)
      beats.push_back(beat_t'({out_data, out_sep, out_neg, out_last}));
    if (mem_rd_en) rd_addrs.push_back(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic neg);
    start   = 1'b1;
    n_exist = neg;
    tick();
    start   = 1'b0;
    n_exist = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    chk(tag, out_valid, 1);
  endtask

  task automatic wait_beats(input int count, input int budget, input string tag);
    int n = 0;
    while (beats.size() < count && n < budget) begin
      tick();
      n++;
    end
    chk(tag, beats.size(), count);
  endtask

  task automatic clear_logs();
    beats.delete();
    rd_addrs.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; n_exist = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_data", out_data, 0);
    chk("rst_flags", {out_sep, out_neg, out_last}, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_addr", mem_addr, 0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [15:0] exp_d [5] = '{16'h0003, 16'h0005, 16'hFFFF, 16'h0002, 16'h0000};
    logic        exp_s [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        exp_l [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int cnt = 0;
    for (int i = 0; i < 5; i++) mem[i] = exp_d[i];
    clear_logs();
    out_ready = 1'b1;
    do_start(1'b0);
    chk("basic_busy", busy, 1);
    while (!out_valid && cnt < 10) begin
      tick();
      cnt++;
    end
    chk("basic_first_latency", cnt, 3);
    wait_idle(60, "basic_done");
    chk("basic_nbeats", beats.size(), 5);
    chk("basic_nreads", rd_addrs.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("basic_data%0d", i), beats[i].data, exp_d[i]);
      chk($sformatf("basic_sep%0d", i), beats[i].sep, exp_s[i]);
      chk($sformatf("basic_last%0d", i), beats[i].last, exp_l[i]);
    end
    chk("basic_overrun", overrun, 0);
  endtask

  task automatic test_neg();
    clear_logs();
    out_ready = 1'b1;
    do_start(1'b1);
    wait_idle(20, "neg_done");
    chk("neg_nbeats", beats.size(), 1);
    chk("neg_data", beats[0].data, 0);
    chk("neg_flag", beats[0].neg, 1);
    chk("neg_last", beats[0].last, 1);
    chk("neg_sep", beats[0].sep, 0);
    chk("neg_nreads", rd_addrs.size(), 0);
  endtask

  task automatic test_stall();
    logic [15:0] exp_d [5] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0000};
    for (int i = 0; i < 5; i++) mem[i] = exp_d[i];
    clear_logs();
    out_ready = 1'b1;
    do_start(1'b0);
    wait_beats(2, 50, "stall_pre_beats");
    out_ready = 1'b0;
    wait_valid(20, "stall_valid_up");
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("stall_data", out_data, 16'h0033);
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_last", out_last, 0);
    end
    chk("stall_no_extra", beats.size(), 2);
    out_ready = 1'b1;
    wait_idle(60, "stall_done");
    chk("stall_nbeats", beats.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("stall_data%0d", i), beats[i].data, exp_d[i]);
  endtask

  task automatic test_overrun();
    int bad = 0;
    int lasts = 0;
    for (int i = 0; i < 16384; i++) mem[i] = 16'(i + 1);
    clear_logs();
    out_ready = 1'b1;
    do_start(1'b0);
    wait_idle(60000, "ovr_done");
    chk("ovr_nbeats", beats.size(), MAX_WORDS);
    chk("ovr_nreads", rd_addrs.size(), MAX_WORDS);
    for (int i = 0; i < beats.size(); i++) begin
      if (beats[i].data != 16'(i + 1)) bad++;
      if (beats[i].last) lasts++;
    end
    chk("ovr_seq_errors", bad, 0);
    chk("ovr_last_count", lasts, 1);
    chk("ovr_last_flag", beats[beats.size()-1].last, 1);
    chk("ovr_last_data", beats[beats.size()-1].data, 16'h3FFF);
    chk("ovr_last_addr", rd_addrs[rd_addrs.size()-1], 14'd16382);
    chk("ovr_flag", overrun, 1);
  endtask

  task automatic test_busy_start();
    mem[0] = 16'h000A; mem[1] = 16'h000B; mem[2] = 16'h0000;
    clear_logs();
    out_ready = 1'b1;
    do_start(1'b0);
    chk("bs_ovr_cleared", overrun, 0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(10, "bs_valid");
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(40, "bs_done");
    repeat (5) tick();
    chk("bs_stays_idle", busy, 0);
    chk("bs_nbeats", beats.size(), 3);
    chk("bs_nreads", rd_addrs.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bs_addr%0d", i), rd_addrs[i], i);
      chk($sformatf("bs_data%0d", i), beats[i].data, mem[i]);
    end
  endtask

  task automatic test_reset_mid();
    mem[0] = 16'h0007; mem[1] = 16'h0008; mem[2] = 16'h0000;
    clear_logs();
    out_ready = 1'b1;
    do_start(1'b0);
    wait_beats(1, 20, "rm_first_beat");
    out_ready = 1'b0;
    wait_valid(10, "rm_hold");
    chk("rm_hold_data", out_data, 16'h0008);
    reset = 1'b1;
    tick();
    chk("rm_valid", out_valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_rd_en", mem_rd_en, 0);
    chk("rm_data", out_data, 0);
    chk("rm_flags", {out_sep, out_neg, out_last}, 0);
    chk("rm_overrun", overrun, 0);
    chk("rm_addr", mem_addr, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    clear_logs();
    repeat (10) tick();
    chk("rm_no_beats", beats.size(), 0);
    chk("rm_no_reads", rd_addrs.size(), 0);
    do_start(1'b0);
    wait_idle(40, "rm_rerun_done");
    chk("rm_rerun_addr0", rd_addrs[0], 0);
    chk("rm_rerun_nbeats", beats.size(), 3);
    chk("rm_rerun_data0", beats[0].data, 16'h0007);
    chk("rm_rerun_last", beats[2].last, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_neg();
    test_stall();
    test_overrun();
    test_busy_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
